// File: rtl/mac_wb_sequencer.sv
// mac_wb_sequencer: shares the M-stage data-memory write port between the pipeline and MAC result bursts.
// Pending MAC result sets queue in a small FIFO and drain as WORDS single-word writes.
module mac_wb_sequencer #(
    parameter int WORDS  = 3,
    parameter int STRIDE = 4,
    parameter int DEPTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mac_write_i,
    input  logic [31:0]           mac_base_i,
    input  logic [32*WORDS-1:0]   mac_res_i,
    input  logic                  st_req_i,
    input  logic                  ld_req_i,
    input  logic [31:0]           st_addr_i,
    input  logic [31:0]           st_data_i,
    output logic                  mem_we_o,
    output logic [31:0]           mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  stall_o,
    output logic                  busy_o,
    output logic                  burst_done_o,
    output logic                  err_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t              r_state, w_next;
    logic [31:0]         r_base [DEPTH];
    logic [32*WORDS-1:0] r_res  [DEPTH];
    logic [AW-1:0]       r_wr, r_rd;
    logic [NW-1:0]       r_count;
    logic [CW-1:0]       r_cnt;
    logic                r_err;
    logic                w_burst, w_last, w_full, w_push, w_pop;
    logic [31:0]         w_addr, w_wdata;

    always_comb begin
        w_burst = r_state == BURST;
        w_last  = w_burst && r_cnt == CW'(WORDS - 1);
        w_full  = r_count == NW'(DEPTH);
        w_pop   = w_last;
        w_push  = mac_write_i && (!w_full || w_pop);
        w_addr  = r_base[r_rd] + 32'(r_cnt) * 32'(STRIDE);
        w_wdata = r_res[r_rd][32*r_cnt +: 32];
        w_next  = r_state;
        if (!w_burst && (r_count != '0 || mac_write_i))
            w_next = BURST;
        else if (w_last && !(r_count > NW'(1) || w_push))
            w_next = IDLE;
    end

    // Outputs are gated by rst_n so the port is quiet for the whole reset interval.
    always_comb begin
        mem_we_o     = rst_n & (w_burst | st_req_i);
        mem_addr_o   = !rst_n ? 32'd0 : w_burst ? w_addr : st_addr_i;
        mem_wdata_o  = !rst_n ? 32'd0 : w_burst ? w_wdata : st_data_i;
        stall_o      = rst_n & ((w_burst & (st_req_i | ld_req_i)) | w_full);
        busy_o       = rst_n & (w_burst | r_count != '0);
        burst_done_o = rst_n & w_last;
        err_o        = rst_n & r_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (w_burst && !w_last) ? r_cnt + CW'(1) : '0;
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + NW'(w_push) - NW'(w_pop);
            if (mac_write_i && w_full && !w_pop) r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_base[r_wr] <= mac_base_i;
            r_res[r_wr]  <= mac_res_i;
        end
    end
endmodule
